pwm_cmd_arbiter: RTL and testbench
==================================

PWM_CMD_ARBITER -- requirements
Module: pwm_cmd_arbiter

Interface
REQ-001 Parameter MIN_W, default 16'd1000: lower clamp for any commanded width (us).
REQ-002 Parameter MAX_W, default 16'd2000: upper clamp for any commanded width (us).
REQ-003 Parameter DEFAULT_W, default 16'd1500: width driven after reset and in failsafe without valid RC input.
REQ-004 Parameter WDT_PERIODS, default 8'd10: PWM periods allowed without a CPU width write before failsafe.
REQ-005 Port clk8M  in  1: single system clock; all logic SHALL run on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous and active-high.
REQ-007 Port wr_en  in  1: one-cycle register write strobe from the SPI slave decoder.
REQ-008 Port wr_addr  in  8: write register address.
REQ-009 Port wr_data  in  16: write data.
REQ-010 Port rd_en  in  1: one-cycle register read strobe.
REQ-011 Port rd_addr  in  8: read register address.
REQ-012 Port rd_data  out  16: read data, registered.
REQ-013 Port rc_width  in  96: six 16-bit RC capture widths, ch1 in [15:0] through ch6 in [95:80].
REQ-014 Port rc_valid  in  1: high while RC capture is locked.
REQ-015 Port period_tick  in  1: one-cycle pulse at the start of each PWM period.
REQ-016 Port pwm_width  out  96: six 16-bit widths to the PWM generator, same packing as rc_width.
REQ-017 Port state  out  2: 2'd0 RC, 2'd1 CPU, 2'd2 FAILSAFE.
REQ-018 Port failsafe  out  1: high exactly while state is FAILSAFE.

Function
REQ-019 Write map SHALL be: 0x05 mode (bit0 only), 0x11..0x16 shadow width ch1..ch6; writes to any other address (e.g. 0x0FFF low byte 0xFF) SHALL be ignored with no side effect.
REQ-020 Shadow width writes SHALL be clamped on entry to [MIN_W, MAX_W].
REQ-021 Read map SHALL be: 0x05 {15'd0,mode}, 0x11..0x16 shadow widths, 0x1F {14'd0,state}, all others 16'd0; rd_data SHALL be valid the cycle after rd_en and hold until the next rd_en.
REQ-022 A read and a write to the same address in one cycle SHALL return the pre-write value.
REQ-023 pwm_width SHALL change only on the cycle following period_tick (commit), never mid-period.
REQ-024 At commit, source SHALL be: RC -> rc_width clamped if rc_valid, else DEFAULT_W; CPU -> shadow widths; FAILSAFE -> rc_width clamped if rc_valid, else DEFAULT_W.
REQ-025 Commit SHALL use shadow values as registered before the tick cycle; a width write coincident with period_tick SHALL commit at the following tick.
REQ-026 State RC -> CPU SHALL occur on a write of mode=1; CPU -> RC on a write of mode=0.
REQ-027 In CPU, a 8-bit watchdog counter SHALL increment on each period_tick and clear on any accepted width write (0x11..0x16); write coincident with tick SHALL clear (write wins).
REQ-028 CPU -> FAILSAFE SHALL occur on the period_tick at which the counter would reach WDT_PERIODS; the same tick's commit SHALL already use the failsafe source.
REQ-029 FAILSAFE -> CPU SHALL occur only on a write of mode=1 (re-arm), clearing the counter; FAILSAFE -> RC on a write of mode=0; width writes in FAILSAFE SHALL update shadows but not exit.
REQ-030 Counter SHALL saturate and be held at 0 in RC and FAILSAFE.
REQ-031 Encoding 2'd3 SHALL never be reached; if entered, next cycle SHALL go to FAILSAFE.

Reset
REQ-032 While rst is high on a clock edge: state=RC, mode=0, failsafe=0, counter=0, all shadows=DEFAULT_W, pwm_width all DEFAULT_W, rd_data=0.
REQ-033 Reset asserted mid-period SHALL take effect on that edge, overriding pending writes and commits; pwm_width SHALL read DEFAULT_W immediately after.

Verification
REQ-034 Write 0x11=1500, mode=1, tick -> ch1 pwm_width=1500 one cycle after tick; read 0x11 -> 1500; read 0x1F -> 1.
REQ-035 CPU mode, write 0x12=2500 and 0x13=400 -> read back 2000 and 1000; committed at next tick.
REQ-036 CPU mode, 10 ticks with no width writes, rc_valid=1, rc ch1=1300 -> state=2, failsafe=1, ch1=1300 on 10th tick commit; rc_valid=0 -> ch1=1500.
REQ-037 Write to 0x0FFF with data 1400 -> no shadow, mode or output change; read 0x16 unchanged.
REQ-038 Write 0x16=1530 in tick cycle -> pwm_width ch6 unchanged at that commit, 1530 at next commit; watchdog count 0.
REQ-039 Assert rst mid-period in CPU mode -> next cycle state=0, all widths 1500, rd_data=0.

Source files
------------

// File: rtl/pwm_cmd_arbiter.sv
// Selects six PWM widths from RC capture, CPU shadow registers or failsafe.
// The CPU path has a period watchdog and a small SPI register map.
module pwm_cmd_arbiter #(
  parameter logic [15:0] MIN_W       = 16'd1000,
  parameter logic [15:0] MAX_W       = 16'd2000,
  parameter logic [15:0] DEFAULT_W   = 16'd1500,
  parameter logic [7:0]  WDT_PERIODS = 8'd10
) (
  input  logic        clk8M,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [15:0] rd_data,
  input  logic [95:0] rc_width,
  input  logic        rc_valid,
  input  logic        period_tick,
  output logic [95:0] pwm_width,
  output logic [1:0]  state,
  output logic        failsafe
);

  typedef enum logic [1:0] {ST_RC = 2'd0, ST_CPU = 2'd1, ST_FS = 2'd2, ST_BAD = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        mode_q;
  logic [7:0]  wdt_cnt;
  logic [15:0] shadow [6];
  logic        mode_wr, width_wr, wdt_expire;
  logic [2:0]  wr_idx;
  logic [95:0] commit_w;
  logic [15:0] rd_mux;

  function automatic logic [15:0] clamp_w(input logic [15:0] w);
    if (w < MIN_W) return MIN_W;
    if (w > MAX_W) return MAX_W;
    return w;
  endfunction

  assign mode_wr    = wr_en && (wr_addr == 8'h05);
  assign width_wr   = wr_en && (wr_addr >= 8'h11) && (wr_addr <= 8'h16);
  assign wr_idx     = wr_addr[2:0] - 3'd1;
  // A width write in the tick cycle restarts the watchdog, so it cannot expire then.
  assign wdt_expire = period_tick && !width_wr && ((wdt_cnt + 8'd1) == WDT_PERIODS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RC:   if (mode_wr && wr_data[0]) state_d = ST_CPU;
      ST_CPU: begin
        if (mode_wr)         state_d = wr_data[0] ? ST_CPU : ST_RC;
        else if (wdt_expire) state_d = ST_FS;
      end
      ST_FS:   if (mode_wr) state_d = wr_data[0] ? ST_CPU : ST_RC;
      default: state_d = ST_FS;
    endcase
  end

  // Commit source follows the next state so a watchdog trip takes effect on its own tick.
  always_comb begin
    commit_w = '0;
    for (int i = 0; i < 6; i++) begin
      if (state_d == ST_CPU)
        commit_w[16*i +: 16] = shadow[i];
      else if (rc_valid)
        commit_w[16*i +: 16] = clamp_w(rc_width[16*i +: 16]);
      else
        commit_w[16*i +: 16] = DEFAULT_W;
    end
  end

  always_comb begin
    rd_mux = 16'd0;
    case (rd_addr)
      8'h05:   rd_mux = {15'd0, mode_q};
      8'h11:   rd_mux = shadow[0];
      8'h12:   rd_mux = shadow[1];
      8'h13:   rd_mux = shadow[2];
      8'h14:   rd_mux = shadow[3];
      8'h15:   rd_mux = shadow[4];
      8'h16:   rd_mux = shadow[5];
      8'h1F:   rd_mux = {14'd0, state_q};
      default: rd_mux = 16'd0;
    endcase
  end

  always_ff @(posedge clk8M) begin
    if (rst) begin
      state_q   <= ST_RC;
      mode_q    <= 1'b0;
      failsafe  <= 1'b0;
      wdt_cnt   <= 8'd0;
      pwm_width <= {6{DEFAULT_W}};
      rd_data   <= 16'd0;
      for (int i = 0; i < 6; i++) shadow[i] <= DEFAULT_W;
    end else begin
      state_q  <= state_d;
      failsafe <= (state_d == ST_FS);
      if (mode_wr) mode_q <= wr_data[0];
      for (int i = 0; i < 6; i++)
        if (width_wr && (wr_idx == 3'(i))) shadow[i] <= clamp_w(wr_data);
      if ((state_d != ST_CPU) || width_wr)
        wdt_cnt <= 8'd0;
      else if (period_tick && (wdt_cnt != 8'hFF))
        wdt_cnt <= wdt_cnt + 8'd1;
      if (period_tick) pwm_width <= commit_w;
      if (rd_en) rd_data <= rd_mux;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pwm_cmd_arbiter.sv
// Directed bench for pwm_cmd_arbiter: cycle-level reference model compared every
// cycle, plus literal expectations for the key scenarios.
module tb_pwm_cmd_arbiter;

  logic        clk8M = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = 8'd0;
  logic [15:0] wr_data = 16'd0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = 8'd0;
  logic [15:0] rd_data;
  logic [95:0] rc_width;
  logic        rc_valid = 1'b0;
  logic        period_tick = 1'b0;
  logic [95:0] pwm_width;
  logic [1:0]  state;
  logic        failsafe;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Reference model: state 0 RC, 1 CPU, 2 FAILSAFE; wdt = ticks since last width write
  int          mState;
  bit          mMode;
  int          mWdt;
  logic [15:0] mShadow [6];
  logic [15:0] mPwm [6];
  logic [15:0] mRd;

  pwm_cmd_arbiter dut (
    .clk8M(clk8M), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rc_width(rc_width),
    .rc_valid(rc_valid), .period_tick(period_tick), .pwm_width(pwm_width),
    .state(state), .failsafe(failsafe)
  );

  always #5 clk8M = ~clk8M;

  function automatic logic [15:0] clampW(input int w);
    if (w < 1000) return 16'd1000;
    if (w > 2000) return 16'd2000;
    return 16'(w);
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then step the clock.
  task automatic applyStimulus(input bit r, input bit we, input logic [7:0] wa, input logic [15:0] wd,
                               input bit re, input logic [7:0] ra, input bit tk);
    int ns, nw;
    bit nm;
    bit isMode, isWidth;
    logic [15:0] nsh [6];
    logic [15:0] np [6];
    logic [15:0] nr;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr = ra; period_tick = tk;
    ns = mState; nm = mMode; nw = mWdt; nr = mRd;
    for (int i = 0; i < 6; i++) begin nsh[i] = mShadow[i]; np[i] = mPwm[i]; end
    if (r) begin
      ns = 0; nm = 1'b0; nw = 0; nr = 16'd0;
      for (int i = 0; i < 6; i++) begin nsh[i] = 16'd1500; np[i] = 16'd1500; end
    end else begin
      isMode  = we && (wa == 8'h05);
      isWidth = we && (wa >= 8'h11) && (wa <= 8'h16);
      if (re) begin
        if (ra == 8'h05) nr = {15'd0, mMode};
        else if (ra >= 8'h11 && ra <= 8'h16) nr = mShadow[ra - 8'h11];
        else if (ra == 8'h1F) nr = 16'(mState);
        else nr = 16'd0;
      end
      if (isMode) nm = wd[0];
      if (isWidth) nsh[wa - 8'h11] = clampW(int'(wd));
      if (isMode) ns = wd[0] ? 1 : 0;
      else if (mState == 1 && tk && !isWidth && (mWdt + 1 == 10)) ns = 2;
      if (ns != 1 || isWidth) nw = 0;
      else if (tk && mWdt < 255) nw = mWdt + 1;
      if (tk)
        for (int i = 0; i < 6; i++)
          np[i] = (ns == 1) ? mShadow[i] :
                  rc_valid ? clampW(int'(rc_width[16*i +: 16])) : 16'd1500;
    end
    @(posedge clk8M);
    #1;
    mState = ns; mMode = nm; mWdt = nw; mRd = nr;
    for (int i = 0; i < 6; i++) begin mShadow[i] = nsh[i]; mPwm[i] = np[i]; end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wrReg(input logic [7:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rdReg(input logic [7:0] a);
    applyStimulus(1'b0, 1'b0, 8'h00, 16'd0, 1'b1, a, 1'b0);
  endtask

  task automatic tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 16'd0, 1'b0, 8'h00, 1'b1);
  endtask

  always @(negedge clk8M) begin
    if (checking) begin
      for (int i = 0; i < 6; i++)
        checkOutput($sformatf("model_pwm_ch%0d", i + 1), 96'(pwm_width[16*i +: 16]), 96'(mPwm[i]));
      checkOutput("model_state", 96'(state), 96'(mState));
      checkOutput("model_failsafe", 96'(failsafe), 96'(mState == 2));
      checkOutput("model_rd_data", 96'(rd_data), 96'(mRd));
    end
  end

  initial begin
    rc_width = {16'd1900, 16'd1100, 16'd1700, 16'd900, 16'd2600, 16'd1300};
    // Reset, with a write pending that must be discarded
    applyStimulus(1'b1, 1'b1, 8'h05, 16'd1, 1'b0, 8'h00, 1'b0);
    checking = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 16'd0, 1'b0, 8'h00, 1'b0);
    checkOutput("lit_reset_state", 96'(state), 96'd0);
    checkOutput("lit_reset_pwm", pwm_width, {6{16'd1500}});
    checkOutput("lit_reset_rd", 96'(rd_data), 96'd0);
    idle(2);
    tick();
    idle(2);

    // RC mode with valid capture: clamped widths committed
    rc_valid = 1'b1;
    tick();
    checkOutput("lit_rc_ch1", 96'(pwm_width[15:0]), 96'd1300);
    checkOutput("lit_rc_ch2_clamp_hi", 96'(pwm_width[31:16]), 96'd2000);
    checkOutput("lit_rc_ch3_clamp_lo", 96'(pwm_width[47:32]), 96'd1000);
    idle(2);

    // Enter CPU mode and commit shadows
    wrReg(8'h11, 16'd1500);
    wrReg(8'h05, 16'd1);
    idle(1);
    tick();
    checkOutput("lit_cpu_ch1", 96'(pwm_width[15:0]), 96'd1500);
    checkOutput("lit_cpu_ch2", 96'(pwm_width[31:16]), 96'd1500);
    rdReg(8'h11);
    checkOutput("lit_rd_0x11", 96'(rd_data), 96'd1500);
    rdReg(8'h1F);
    checkOutput("lit_rd_state_cpu", 96'(rd_data), 96'd1);
    idle(2);

    // Clamp on entry
    wrReg(8'h12, 16'd2500);
    wrReg(8'h13, 16'd400);
    rdReg(8'h12);
    checkOutput("lit_rd_0x12_clamp", 96'(rd_data), 96'd2000);
    rdReg(8'h13);
    checkOutput("lit_rd_0x13_clamp", 96'(rd_data), 96'd1000);
    checkOutput("lit_ch2_before_tick", 96'(pwm_width[31:16]), 96'd1500);
    tick();
    checkOutput("lit_ch2_commit", 96'(pwm_width[31:16]), 96'd2000);
    checkOutput("lit_ch3_commit", 96'(pwm_width[47:32]), 96'd1000);

    // Unmapped write has no effect
    wrReg(8'hFF, 16'd1400);
    rdReg(8'h16);
    checkOutput("lit_rd_0x16_unchanged", 96'(rd_data), 96'd1500);
    rdReg(8'h05);
    checkOutput("lit_rd_mode", 96'(rd_data), 96'd1);

    // Width write coincident with tick commits one period later
    applyStimulus(1'b0, 1'b1, 8'h16, 16'd1530, 1'b0, 8'h00, 1'b1);
    checkOutput("lit_ch6_same_tick", 96'(pwm_width[95:80]), 96'd1500);
    idle(3);
    tick();
    checkOutput("lit_ch6_next_tick", 96'(pwm_width[95:80]), 96'd1530);

    // Read and write of one address in one cycle returns old value
    applyStimulus(1'b0, 1'b1, 8'h14, 16'd1800, 1'b1, 8'h14, 1'b0);
    checkOutput("lit_rd_pre_write", 96'(rd_data), 96'd1500);
    rdReg(8'h14);
    checkOutput("lit_rd_post_write", 96'(rd_data), 96'd1800);
    idle(2);

    // Watchdog: nine quiet periods stay in CPU, the tenth trips failsafe
    for (int p = 0; p < 9; p++) begin
      tick();
      idle(2);
    end
    checkOutput("lit_wdt_9_state", 96'(state), 96'd1);
    tick();
    checkOutput("lit_wdt_10_state", 96'(state), 96'd2);
    checkOutput("lit_wdt_10_failsafe", 96'(failsafe), 96'd1);
    checkOutput("lit_wdt_10_ch1", 96'(pwm_width[15:0]), 96'd1300);
    idle(2);
    rc_valid = 1'b0;
    tick();
    checkOutput("lit_fs_default_ch1", 96'(pwm_width[15:0]), 96'd1500);
    idle(1);

    // Width write in failsafe updates shadow only; re-arm and exit
    wrReg(8'h11, 16'd1200);
    checkOutput("lit_fs_hold", 96'(state), 96'd2);
    wrReg(8'h05, 16'd1);
    checkOutput("lit_rearm_state", 96'(state), 96'd1);
    tick();
    checkOutput("lit_rearm_ch1", 96'(pwm_width[15:0]), 96'd1200);
    wrReg(8'h05, 16'd0);
    checkOutput("lit_to_rc_state", 96'(state), 96'd0);
    wrReg(8'h05, 16'd1);
    rdReg(8'h11);
    idle(3);

    // Mid-period reset overrides a pending write, read and tick
    applyStimulus(1'b1, 1'b1, 8'h11, 16'd1900, 1'b1, 8'h11, 1'b1);
    checkOutput("lit_rst_state", 96'(state), 96'd0);
    checkOutput("lit_rst_pwm", pwm_width, {6{16'd1500}});
    checkOutput("lit_rst_rd", 96'(rd_data), 96'd0);
    rdReg(8'h11);
    checkOutput("lit_rst_shadow", 96'(rd_data), 96'd1500);
    rdReg(8'h05);
    checkOutput("lit_rst_mode", 96'(rd_data), 96'd0);
    idle(2);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
